// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline interlock scoreboard.
package hazard_pkg;

   localparam int unsigned REG_AW = 5;
   localparam logic [REG_AW-1:0] ZERO_REG = '0;

   // One in-flight destination entry: valid flag plus destination register.
   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] dst;
   } slot_t;

endpackage

// File: rtl/pipeline_hazard_scoreboard_if.sv
// ID-stage operand/destination bus plus the interlock responses.
interface pipeline_hazard_scoreboard_if #(
   parameter int unsigned REG_AW = hazard_pkg::REG_AW,
   parameter int unsigned CNT_W  = 16
);
   logic              hold;
   logic [REG_AW-1:0] id_rs_addr;
   logic [REG_AW-1:0] id_rt_addr;
   logic              id_uses_rs;
   logic              id_uses_rt;
   logic              id_reg_w;
   logic [REG_AW-1:0] id_dst_addr;
   logic              stall;
   logic              bubble;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output hold, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_reg_w, id_dst_addr,
      input  stall, bubble, stall_cnt
   );

   modport slave (
      input  hold, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_reg_w, id_dst_addr,
      output stall, bubble, stall_cnt
   );
endinterface

// File: rtl/hazard_match.sv
// Compares one scoreboard slot against the source operands of the ID instruction.
module hazard_match
   import hazard_pkg::*;
(
   input  logic              en,
   input  slot_t             slot,
   input  logic [REG_AW-1:0] rs_addr,
   input  logic [REG_AW-1:0] rt_addr,
   input  logic              uses_rs,
   input  logic              uses_rt,
   output logic              hit_c
);

   logic rs_hit_c;
   logic rt_hit_c;

   assign rs_hit_c = uses_rs && (rs_addr == slot.dst);
   assign rt_hit_c = uses_rt && (rt_addr == slot.dst);

   // $0 is hard-wired, so a slot targeting it can never cause a dependency.
   assign hit_c = en && slot.v && (slot.dst != ZERO_REG) && (rs_hit_c || rt_hit_c);

endmodule

// File: rtl/pipeline_hazard_scoreboard.sv
// Interlock controller for a forwarding-less 5-stage pipeline: EX/MEM/WB
// destination scoreboard, stall/bubble generation and a saturating stall counter.
module pipeline_hazard_scoreboard
   import hazard_pkg::slot_t;
#(
   parameter bit          WB_BYPASS = 1'b1,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned REG_AW    = hazard_pkg::REG_AW
) (
   input logic                          clk,
   input logic                          rst,
   pipeline_hazard_scoreboard_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   slot_t             ex_q;
   slot_t             mem_q;
   slot_t             wb_q;
   slot_t             ex_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [REG_AW-1:0] id_dst;
   logic              hit_ex_c;
   logic              hit_mem_c;
   logic              hit_wb_c;
   logic              stall_c;

   assign id_dst = bus.id_dst_addr;

   hazard_match u_match_ex (
      .en      (1'b1),
      .slot    (ex_q),
      .rs_addr (bus.id_rs_addr),
      .rt_addr (bus.id_rt_addr),
      .uses_rs (bus.id_uses_rs),
      .uses_rt (bus.id_uses_rt),
      .hit_c   (hit_ex_c)
   );

   hazard_match u_match_mem (
      .en      (1'b1),
      .slot    (mem_q),
      .rs_addr (bus.id_rs_addr),
      .rt_addr (bus.id_rt_addr),
      .uses_rs (bus.id_uses_rs),
      .uses_rt (bus.id_uses_rt),
      .hit_c   (hit_mem_c)
   );

   // With write-before-read register file the WB producer is already visible to ID.
   hazard_match u_match_wb (
      .en      (!WB_BYPASS),
      .slot    (wb_q),
      .rs_addr (bus.id_rs_addr),
      .rt_addr (bus.id_rt_addr),
      .uses_rs (bus.id_uses_rs),
      .uses_rt (bus.id_uses_rt),
      .hit_c   (hit_wb_c)
   );

   // The external freeze already holds the pipe, so no local stall is raised.
   assign stall_c       = (hit_ex_c || hit_mem_c || hit_wb_c) && !bus.hold;
   assign bus.stall     = stall_c;
   assign bus.bubble    = stall_c;
   assign bus.stall_cnt = cnt_q;

   // Entry for the EX slot: a bubble on stall, otherwise the ID destination.
   always_comb begin
      ex_d = '0;
      if (!stall_c) begin
         ex_d.v   = bus.id_reg_w && (id_dst != REG_AW'(0));
         ex_d.dst = id_dst;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         cnt_q <= '0;
      end else if (!bus.hold) begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= ex_d;
         if (stall_c && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Scoreboard bench: two scoreboards (WB bypass on with 4-bit counter, bypass off
// with 16-bit counter) share ID stimulus; expected cycles are queued and checked.
module tb_pipeline_hazard_scoreboard;

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic       rw;
      logic [4:0] dst;
   } instr_t;

   typedef struct {
      string name;
      logic  sa;
      int    ca;
      logic  chkb;
      logic  sb;
      int    cb;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst;
   exp_t   q[$];
   int     checks   = 0;
   int     failures = 0;

   always #5 clk = ~clk;

   pipeline_hazard_scoreboard_if #(.REG_AW(5), .CNT_W(4))  ifa ();
   pipeline_hazard_scoreboard_if #(.REG_AW(5), .CNT_W(16)) ifb ();

   pipeline_hazard_scoreboard #(.WB_BYPASS(1'b1), .CNT_W(4), .REG_AW(5)) u_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   pipeline_hazard_scoreboard #(.WB_BYPASS(1'b0), .CNT_W(16), .REG_AW(5)) u_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   function automatic instr_t r3(int d, int s, int t);
      instr_t i;
      i.rs = 5'(s); i.rt = 5'(t); i.urs = 1'b1; i.urt = 1'b1; i.rw = 1'b1; i.dst = 5'(d);
      return i;
   endfunction

   function automatic instr_t lw(int t, int base);
      instr_t i;
      i.rs = 5'(base); i.rt = 5'(t); i.urs = 1'b1; i.urt = 1'b0; i.rw = 1'b1; i.dst = 5'(t);
      return i;
   endfunction

   function automatic instr_t sw(int t, int base);
      instr_t i;
      i.rs = 5'(base); i.rt = 5'(t); i.urs = 1'b1; i.urt = 1'b1; i.rw = 1'b0; i.dst = 5'(t);
      return i;
   endfunction

   function automatic instr_t nop();
      instr_t i;
      i.rs = 5'd0; i.rt = 5'd0; i.urs = 1'b0; i.urt = 1'b0; i.rw = 1'b0; i.dst = 5'd0;
      return i;
   endfunction

   task automatic apply(instr_t i, logic h);
      ifa.id_rs_addr = i.rs;  ifb.id_rs_addr = i.rs;
      ifa.id_rt_addr = i.rt;  ifb.id_rt_addr = i.rt;
      ifa.id_uses_rs = i.urs; ifb.id_uses_rs = i.urs;
      ifa.id_uses_rt = i.urt; ifb.id_uses_rt = i.urt;
      ifa.id_reg_w   = i.rw;  ifb.id_reg_w   = i.rw;
      ifa.id_dst_addr = i.dst; ifb.id_dst_addr = i.dst;
      ifa.hold = h;           ifb.hold = h;
   endtask

   task automatic push(string name, logic sa, int ca, logic chkb, logic sb, int cb);
      exp_t e;
      e.name = name; e.sa = sa; e.ca = ca; e.chkb = chkb; e.sb = sb; e.cb = cb;
      q.push_back(e);
   endtask

   // One pipeline cycle: drive just after the edge, queue the expected outputs.
   task automatic cyc(string name, logic r, instr_t i, logic h,
                      logic sa, int ca, logic chkb, logic sb, int cb);
      @(posedge clk);
      #1;
      rst = r;
      apply(i, h);
      push(name, sa, ca, chkb, sb, cb);
   endtask

   task automatic do_reset(string name);
      cyc({name, "_rst"}, 1'b1, r3(4, 3, 5), 1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
      cyc({name, "_rel"}, 1'b0, nop(), 1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
   endtask

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every sampled cycle consumes one queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk({e.name, "/a.stall"},  int'(ifa.stall),     int'(e.sa));
         chk({e.name, "/a.bubble"}, int'(ifa.bubble),    int'(e.sa));
         chk({e.name, "/a.cnt"},    int'(ifa.stall_cnt), e.ca);
         if (e.chkb) begin
            chk({e.name, "/b.stall"},  int'(ifb.stall),     int'(e.sb));
            chk({e.name, "/b.bubble"}, int'(ifb.bubble),    int'(e.sb));
            chk({e.name, "/b.cnt"},    int'(ifb.stall_cnt), e.cb);
         end
      end
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int ca;
      rst = 1'b1;
      apply(nop(), 1'b0);

      // Back-to-back RAW: 2 stall cycles with WB bypass, 3 without.
      do_reset("t1");
      cyc("t1_prod", 0, r3(3, 1, 2), 0, 0, 0, 1, 0, 0);
      cyc("t1_c1",   0, r3(4, 3, 5), 0, 1, 0, 1, 1, 0);
      cyc("t1_c2",   0, r3(4, 3, 5), 0, 1, 1, 1, 1, 1);
      cyc("t1_c3",   0, r3(4, 3, 5), 0, 0, 2, 1, 1, 2);
      cyc("t1_end",  0, nop(),       0, 0, 2, 1, 0, 3);

      // lw / independent / sw using Rt, then $0 producer and $0 readers.
      do_reset("t3");
      cyc("t3_lw",   0, lw(8, 0),    0, 0, 0, 1, 0, 0);
      cyc("t3_ind",  0, r3(9, 1, 2), 0, 0, 0, 1, 0, 0);
      cyc("t3_sw1",  0, sw(8, 0),    0, 1, 0, 1, 1, 0);
      cyc("t3_sw2",  0, sw(8, 0),    0, 0, 1, 1, 1, 1);
      cyc("t3_nop",  0, nop(),       0, 0, 1, 1, 0, 2);
      cyc("t3_wr0",  0, r3(0, 1, 2), 0, 0, 1, 1, 0, 2);
      cyc("t3_rd0",  0, r3(5, 0, 0), 0, 0, 1, 1, 0, 2);

      // Hold on the first stall cycle for 4 cycles, then the stall resumes.
      do_reset("t4");
      cyc("t4_prod", 0, r3(3, 1, 2), 0, 0, 0, 1, 0, 0);
      for (int k = 0; k < 4; k++) begin
         cyc("t4_hold", 0, r3(4, 3, 5), 1, 0, 0, 1, 0, 0);
      end
      cyc("t4_c1",   0, r3(4, 3, 5), 0, 1, 0, 1, 1, 0);
      cyc("t4_c2",   0, r3(4, 3, 5), 0, 1, 1, 1, 1, 1);
      cyc("t4_c3",   0, r3(4, 3, 5), 0, 0, 2, 1, 1, 2);
      cyc("t4_end",  0, nop(),       0, 0, 2, 1, 0, 3);

      // Same register on Rs and Rt is a single stall condition.
      do_reset("t5");
      cyc("t5_prod", 0, r3(7, 1, 2), 0, 0, 0, 1, 0, 0);
      cyc("t5_c1",   0, r3(6, 7, 7), 0, 1, 0, 1, 1, 0);
      cyc("t5_c2",   0, r3(6, 7, 7), 0, 1, 1, 1, 1, 1);
      cyc("t5_c3",   0, r3(6, 7, 7), 0, 0, 2, 1, 1, 2);

      // 20 stall cycles on the 4-bit counter: it must stop at 15.
      do_reset("t6");
      ca = 0;
      for (int p = 0; p < 10; p++) begin
         cyc("t6_prod", 0, r3(3, 1, 2), 0, 0, ca, 0, 0, 0);
         cyc("t6_s1",   0, r3(4, 3, 5), 0, 1, ca, 0, 0, 0);
         ca = (ca < 15) ? ca + 1 : 15;
         cyc("t6_s2",   0, r3(4, 3, 5), 0, 1, ca, 0, 0, 0);
         ca = (ca < 15) ? ca + 1 : 15;
         cyc("t6_go",   0, r3(4, 3, 5), 0, 0, ca, 0, 0, 0);
      end
      cyc("t6_sat", 0, nop(), 0, 0, 15, 0, 0, 0);

      // Asynchronous reset in the middle of a stall, away from any clock edge.
      do_reset("t7");
      cyc("t7_prod", 0, r3(3, 1, 2), 0, 0, 0, 1, 0, 0);
      cyc("t7_c1",   0, r3(4, 3, 5), 0, 1, 0, 1, 1, 0);
      @(posedge clk);
      #1;
      apply(r3(4, 3, 5), 1'b0);
      #2;
      rst = 1'b1;
      push("t7_async", 0, 0, 1, 0, 0);
      cyc("t7_after", 0, r3(4, 3, 5), 0, 0, 0, 1, 0, 0);

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_scoreboard.md
Name: pipeline_hazard_scoreboard

Overview:
Interlock controller for the 5-stage MIPS pipeline, which has no forwarding network. It tracks destination registers of in-flight instructions in a 3-slot shift scoreboard aligned to the EX, MEM and WB stages. It stalls PC and IF/ID, and injects a bubble into ID/EX, while the instruction in ID reads a register still pending write. It also keeps a saturating stall-cycle counter for performance checks.

Parameters:
WB_BYPASS, 1, 1 = RF returns same-cycle write data (write-before-read), so the WB slot is not a hazard; 0 = WB slot also hazards
CNT_W, 16, width of stall counter
REG_AW, 5, register address width

Ports:
clk  in  1  pipeline clock
rst  in  1  reset, asynchronous, active-high
hold  in  1  global freeze; scoreboard and counter keep state
id_rs_addr  in  REG_AW  Rs field of instruction in ID
id_rt_addr  in  REG_AW  Rt field of instruction in ID
id_uses_rs  in  1  ID instruction reads Rs
id_uses_rt  in  1  ID instruction reads Rt (R-type, sw)
id_reg_w  in  1  ID instruction writes a register (Reg_w from Control)
id_dst_addr  in  REG_AW  resolved destination (Rd if Reg_dst, else Rt)
stall  out  1  hold PC and IF/ID this cycle
bubble  out  1  force ID/EX control bits (Reg_w, Mem_w, Mem_r) to 0 at next edge
stall_cnt  out  CNT_W  total stalled cycles since reset

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named rst.
- State: three slots, ex/mem/wb, each holding {v, dst}.
- Reset: all v=0, all dst=0, stall_cnt=0. stall=0 and bubble=0 while in reset; both are combinational from the cleared state.
- Hazard match, per slot s: s.v && s.dst!=0 && ((id_uses_rs && id_rs_addr==s.dst) || (id_uses_rt && id_rt_addr==s.dst)).
- Hazard: match(ex) || match(mem) || (!WB_BYPASS && match(wb)).
- Outputs: stall = hazard && !hold; bubble = stall. Both are combinational, with no added latency.
- Register $0 never hazards, whether as source or destination.
- Each rising clk edge with hold=0:
  - wb <= mem; mem <= ex.
  - ex <= stall ? {0,0} : {id_reg_w && id_dst_addr!=0, id_dst_addr}.
  - If stall, stall_cnt <= stall_cnt+1, saturating at 2^CNT_W-1 with no wrap.
- hold=1: all state frozen. stall is forced to 0 because the external freeze already holds the pipe.
- Stall length for a dependent instruction immediately following its producer:
  - WB_BYPASS=1: 2 cycles.
  - WB_BYPASS=0: 3 cycles.
  - With one independent instruction between producer and consumer, subtract 1.
- Multiple matches in different slots: stall persists until the youngest matching slot clears.
- Load-use needs no special case; lw behaves like any Reg_w producer.
- Same register matched by both Rs and Rt: single stall condition, no double count.
- rst asserted mid-stall: scoreboard cleared immediately, stall deasserts asynchronously, counter returns to 0.
- Producer with id_reg_w=0 (sw) or dst=0: slot enters with v=0.

Decomposition:
- Shared package hazard_pkg holds:
  - REG_AW and the ZERO_REG constant.
  - Slot struct {v, dst}.
- Natural sub-module: hazard_match (combinational compare of one slot against the ID sources). Instantiated 3 times; the WB instance is gated by WB_BYPASS.
- Counter and shift register stay in the top module.

Test Plan:
- add $3,$1,$2 then add $4,$3,$5 (WB_BYPASS=1) -> stall=1 for exactly 2 cycles, ex slot holds a bubble each stall cycle, stall_cnt=2.
- Same sequence with WB_BYPASS=0 -> stall for 3 cycles, stall_cnt=3.
- lw $8,0($0), independent add, then sw $8,4($0) (uses_rt) -> 1 stall cycle; no stall when the producer writes $0.
- hold=1 asserted on the 1st stall cycle for 4 cycles -> stall=0 during hold, slots unchanged, remaining stall count resumes after hold drops.
- Force stall_cnt near saturation (CNT_W=4, 20 stall cycles) -> counter stops at 15.
- Assert rst asynchronously mid-stall, off a clock edge -> stall, bubble and stall_cnt go to 0 without waiting for clk.
